// File: rtl/receive_engine.sv
// UART receiver: 2-flop synchronised Rx, mid-bit sampling, 7/8 data bits, optional parity.
// Presents the byte on UART_DS with sticky RxRDY/PERR/FERR/OVF status cleared by READS.
`timescale 1ns/1ps
module receive_engine #(
    parameter int unsigned DIV_OVERRIDE = 0,
    parameter int unsigned BT_W         = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic [3:0] BAUD,
    input  logic       READS,
    output logic [7:0] UART_DS,
    output logic       RxRDY,
    output logic       PERR,
    output logic       FERR,
    output logic       OVF
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StDone} state_t;

    function automatic logic [BT_W-1:0] f_bit_time(input logic [3:0] baud);
        logic [BT_W-1:0] v;
        case (baud)
            4'h0:    v = BT_W'(333333);
            4'h1:    v = BT_W'(83333);
            4'h2:    v = BT_W'(41667);
            4'h3:    v = BT_W'(20833);
            4'h4:    v = BT_W'(10417);
            4'h5:    v = BT_W'(5208);
            4'h6:    v = BT_W'(2604);
            4'h7:    v = BT_W'(1736);
            4'h8:    v = BT_W'(868);
            4'h9:    v = BT_W'(434);
            4'hA:    v = BT_W'(217);
            default: v = BT_W'(109);
        endcase
        if (DIV_OVERRIDE != 0) v = BT_W'(DIV_OVERRIDE);
        return v;
    endfunction

    state_t          r_state, w_state_d;
    logic            r_rx_meta, r_rxs;
    logic [BT_W-1:0] r_cnt, r_bt;
    logic [3:0]      r_bitcnt;
    logic [9:0]      r_shift;
    logic            r_eight, r_pen, r_ohel;
    logic [7:0]      r_data;
    logic            r_rdy, r_perr, r_ferr, r_ovf;

    logic [BT_W-1:0] w_bt_sel;
    logic            w_tick;
    logic [3:0]      w_nbits, w_bitcnt_inc;
    logic [9:0]      w_frame;
    logic [7:0]      w_data;
    logic            w_par, w_perr, w_ferr;

    assign w_bt_sel     = f_bit_time(BAUD);
    assign w_tick       = (r_cnt == '0);
    assign w_nbits      = (r_eight ? 4'd8 : 4'd7) + {3'b000, r_pen} + 4'd1;
    assign w_bitcnt_inc = r_bitcnt + 4'd1;
    // Bits enter at the MSB, so the frame ends up left-justified in the shift register.
    assign w_frame      = r_shift >> (4'd10 - w_nbits);
    assign w_data       = r_eight ? w_frame[7:0] : {1'b0, w_frame[6:0]};
    assign w_par        = r_eight ? w_frame[8] : w_frame[7];
    assign w_perr       = r_pen & (^w_data ^ w_par ^ r_ohel);
    assign w_ferr       = ~w_frame[w_nbits - 4'd1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (!r_rxs) w_state_d = StStart;
            StStart: if (w_tick) w_state_d = r_rxs ? StIdle : StData;
            StData:  if (w_tick && (w_bitcnt_inc == w_nbits)) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Counters reload with N-1 so a terminal count of 0 spaces samples exactly N clks apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bt     <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_eight  <= 1'b0;
            r_pen    <= 1'b0;
            r_ohel   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!r_rxs) begin
                        r_eight <= EIGHT;
                        r_pen   <= PEN;
                        r_ohel  <= OHEL;
                        r_bt    <= w_bt_sel;
                        r_cnt   <= (w_bt_sel >> 1) - BT_W'(1);
                    end
                end
                StStart: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - BT_W'(1);
                    end else if (!r_rxs) begin
                        r_cnt    <= r_bt - BT_W'(1);
                        r_bitcnt <= '0;
                    end
                end
                StData: begin
                    if (w_tick) begin
                        r_shift  <= {r_rxs, r_shift[9:1]};
                        r_bitcnt <= w_bitcnt_inc;
                        r_cnt    <= r_bt - BT_W'(1);
                    end else begin
                        r_cnt <= r_cnt - BT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_rdy  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == StDone) begin
            r_data <= w_data;
            r_rdy  <= 1'b1;
            r_perr <= w_perr;
            r_ferr <= w_ferr;
            r_ovf  <= ~READS & (r_rdy | r_ovf);
        end else if (READS) begin
            r_rdy  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end
    end

    assign UART_DS = r_data;
    assign RxRDY   = r_rdy;
    assign PERR    = r_perr;
    assign FERR    = r_ferr;
    assign OVF     = r_ovf;

endmodule

// File: tb/tb_receive_engine.sv
// Self-checking bench for receive_engine: directed frames, scoreboard queue popped by a monitor
// whenever RxRDY presents a new frame; second instance checks the BAUD=B bit time.
`timescale 1ns/1ps
module tb_receive_engine;

    logic       clk = 1'b0;
    logic       rst, Rx, Rx2, EIGHT, PEN, OHEL, READS, READS2;
    logic [3:0] BAUD;
    logic [7:0] ds, ds2;
    logic       rdy, perr, ferr, ovf, rdy2, perr2, ferr2, ovf2;

    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];   // {data, perr, ferr, ovf}

    always #5 clk = ~clk;

    receive_engine #(.DIV_OVERRIDE(16), .BT_W(19)) u_dut (
        .clk(clk), .rst(rst), .Rx(Rx), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .BAUD(BAUD),
        .READS(READS), .UART_DS(ds), .RxRDY(rdy), .PERR(perr), .FERR(ferr), .OVF(ovf)
    );

    receive_engine #(.DIV_OVERRIDE(0), .BT_W(19)) u_dut_baud (
        .clk(clk), .rst(rst), .Rx(Rx2), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .BAUD(BAUD),
        .READS(READS2), .UART_DS(ds2), .RxRDY(rdy2), .PERR(perr2), .FERR(ferr2), .OVF(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Frame: start, data LSB first, optional parity, stop; called right after a negedge.
    task automatic send_frame(input bit sel, input int bt, input logic [7:0] d, input logic e8,
                              input logic pen, input logic ohel, input logic par,
                              input logic stop);
        EIGHT = e8;
        PEN   = pen;
        OHEL  = ohel;
        if (sel) Rx2 = 1'b0; else Rx = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < (e8 ? 8 : 7); i++) begin
            if (sel) Rx2 = d[i]; else Rx = d[i];
            repeat (bt) @(negedge clk);
        end
        if (pen) begin
            if (sel) Rx2 = par; else Rx = par;
            repeat (bt) @(negedge clk);
        end
        if (sel) Rx2 = stop; else Rx = stop;
        repeat (bt) @(negedge clk);
        if (sel) Rx2 = 1'b1; else Rx = 1'b1;
    endtask

    task automatic read_strobe();
        READS = 1'b1;
        @(negedge clk);
        READS = 1'b0;
    endtask

    // Monitor: a new frame is visible when RxRDY rises or its payload changes while RxRDY=1.
    initial begin : monitor
        logic [10:0] cur, prev_vec, exp;
        logic        prev_rdy;
        prev_rdy = 1'b0;
        prev_vec = '0;
        forever begin
            @(negedge clk);
            cur = {ds, perr, ferr, ovf};
            if (rdy && (!prev_rdy || cur != prev_vec)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame: got %h, expected no frame", cur);
                end else begin
                    exp = exp_q.pop_front();
                    check("frame{ds,perr,ferr,ovf}", {21'b0, cur}, {21'b0, exp});
                end
            end
            prev_rdy = rdy;
            prev_vec = cur;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int lat;
        rst = 1'b1; Rx = 1'b1; Rx2 = 1'b1; READS = 1'b0; READS2 = 1'b0;
        EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; BAUD = 4'hB;
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'b0, rdy, ds, perr, ferr, ovf}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5
        exp_q.push_back({8'hA5, 3'b000});
        send_frame(1'b0, 16, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("8n1_rxrdy", {31'b0, rdy}, 32'h1);
        read_strobe();
        check("reads_clears_rxrdy", {31'b0, rdy}, 32'h0);
        check("reads_holds_data", {24'b0, ds}, 32'hA5);

        // 8E1: parity 1 is wrong for 0xA5 (four ones), parity 0 is right
        exp_q.push_back({8'hA5, 3'b100});
        send_frame(1'b0, 16, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        read_strobe();
        check("reads_clears_perr", {31'b0, perr}, 32'h0);
        exp_q.push_back({8'hA5, 3'b000});
        send_frame(1'b0, 16, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        read_strobe();

        // 7O1 0x25 (three ones) with parity 0
        exp_q.push_back({8'h25, 3'b000});
        send_frame(1'b0, 16, 8'h25, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        read_strobe();

        // Framing error on 0x3C
        exp_q.push_back({8'h3C, 3'b010});
        send_frame(1'b0, 16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("ferr_rxrdy", {31'b0, rdy}, 32'h1);
        read_strobe();
        check("reads_clears_ferr", {31'b0, ferr}, 32'h0);
        repeat (20) @(negedge clk);

        // 5-clk glitch is shorter than a half bit: no frame
        Rx = 1'b0;
        repeat (5) @(negedge clk);
        Rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_rxrdy", {31'b0, rdy}, 32'h0);

        // Overflow: two frames, no read in between
        exp_q.push_back({8'h11, 3'b000});
        exp_q.push_back({8'h22, 3'b001});
        send_frame(1'b0, 16, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 16, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        read_strobe();
        check("reads_clears_ovf", {30'b0, rdy, ovf}, 32'h0);

        // READS lands on the DONE clk of the second frame (edge 156 after start): no OVF
        exp_q.push_back({8'h11, 3'b000});
        exp_q.push_back({8'h22, 3'b000});
        send_frame(1'b0, 16, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(1'b0, 16, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                READS = 1'b1;
                @(negedge clk);
                READS = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("reads_on_done_keeps_rxrdy", {31'b0, rdy}, 32'h1);

        // Reset in the middle of a frame
        Rx = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        Rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midframe_reset_outputs", {20'b0, rdy, ds, perr, ferr, ovf}, 32'h0);
        repeat (20) @(negedge clk);
        check("midframe_reset_no_frame", {31'b0, rdy}, 32'h0);
        exp_q.push_back({8'h5A, 3'b000});
        send_frame(1'b0, 16, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        read_strobe();

        // BAUD=B without override: 109-clk bits, RxRDY after 4 + 54 + 9*109 = 1039 edges
        lat = 0;
        fork
            send_frame(1'b1, 109, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 1; i <= 1200; i++) begin
                    @(posedge clk);
                    #1;
                    if (rdy2 && lat == 0) lat = i;
                end
            end
        join
        n_cmp++;
        if (lat < 1037 || lat > 1041) begin
            n_err++;
            $display("FAIL baud_b_latency: got %0d clks, expected 1037..1041", lat);
        end
        check("baud_b_frame", {20'b0, rdy2, ds2, perr2, ferr2, ovf2}, {20'b0, 1'b1, 8'hC3, 3'b000});

        repeat (10) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL frames_outstanding: got %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
